fetch_prefetch_unit: RTL and testbench

- Replaces the bare PC register, PC+4 adder and instruction-memory hookup at the front of the 5-stage RISC-V pipeline.
- Owns the fetch PC and issues in-order requests to a variable-latency instruction memory over a req/gnt/rvalid interface.
- Buffers returned words with their PCs and hands them to the IF/ID pipe register over a valid/ready handshake.
- Accepts a redirect from the MEM-stage taken-branch logic: flushes buffered words and discards in-flight responses.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_prefetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared front-end types: machine width, instruction size, fetch FSM states
// and the {pc, instr} entry carried from fetch to IF/ID.
package cpu_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with combinational head and a flush that overrides
// any same-cycle push or pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Front-end fetch: owns the PC, issues in-order imem requests under a credit
// limit, buffers returned words with their PCs and drops stale ones on redirect.
module fetch_prefetch_unit import cpu_pkg::*; #(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            instr_ready_i
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   buf_count, pend_count;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] pend_head;
    fetch_entry_t    head_entry, push_entry;
    logic            grant, keep_rsp, pop_entry, buf_nonempty;

    assign buf_nonempty = (buf_count != '0);
    // Credit covers both in-flight requests and buffered words, so every
    // response that is kept always finds room in the entry FIFO.
    assign occupancy  = (CW+1)'(outstanding_q) + (CW+1)'(buf_count);
    assign imem_req_o = (state_q != BOOT) && !redirect_i && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign grant      = imem_req_o && imem_gnt_i;
    assign keep_rsp   = imem_rvalid_i && (discard_q == '0) && !redirect_i;

    assign instr_valid_o = buf_nonempty && !redirect_i;
    assign pop_entry     = instr_valid_o && instr_ready_i;
    assign instr_o       = buf_nonempty ? head_entry.instr : '0;
    assign pc_o          = buf_nonempty ? head_entry.pc    : '0;

    assign push_entry.pc    = pend_head;
    assign push_entry.instr = imem_rdata_i;

    always_comb begin
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
        fetch_pc_d    = fetch_pc_q;
        discard_d     = discard_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            discard_d  = outstanding_d;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            DRAIN:   if (discard_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (redirect_i) state_d = (discard_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Addresses of live requests, popped in order as their words return.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pend_q (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .push_i      (grant),
        .push_data_i (fetch_pc_q),
        .pop_i       (keep_rsp),
        .clear_i     (redirect_i),
        .count_o     (pend_count),
        .head_o      (pend_head)
    );

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_entry_q (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .push_i      (keep_rsp),
        .push_data_i (push_entry),
        .pop_i       (pop_entry),
        .clear_i     (redirect_i),
        .count_o     (buf_count),
        .head_o      (head_entry)
    );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed and randomized bench for fetch_prefetch_unit against a queue-level
// model of the fetch stream and an in-order variable-latency memory.
module tb_fetch_prefetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t       mq[$];
    ent_t        expq[$];
    logic [31:0] pendq[$];
    logic [31:0] delivered[$];
    int          cyc = 0, n_checks = 0, n_fail = 0;
    int          m_out, m_discard, since_rst, grants;
    logic [31:0] m_fetch_pc;
    int          lat_min = 1, lat_max = 1, max_if = 16;
    bit          rand_gnt = 1'b0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        pendq.delete();
        m_out      = 0;
        m_discard  = 0;
        since_rst  = 0;
        m_fetch_pc = RESET_PC;
    endtask

    // One clock: memory drives gnt/rvalid, outputs are checked at the falling
    // edge, then the model advances by the transactions seen in this cycle.
    task automatic cycle();
        bit          g, r, exp_req, exp_valid, do_push;
        ent_t        ne;
        logic [31:0] pa;
        imem_gnt_i = rand_gnt ? 1'($urandom_range(1, 0)) : 1'b1;
        if (mq.size() >= max_if) imem_gnt_i = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        @(negedge clk_i);
        s_req = imem_req_o; s_addr = imem_addr_o; s_valid = instr_valid_o; s_pc = pc_o;
        g = imem_req_o && imem_gnt_i;
        r = imem_rvalid_i;
        if (r) void'(mq.pop_front());
        if (g) mq.push_back('{addr: imem_addr_o, due: cyc + int'($urandom_range(lat_max, lat_min))});
        if (!rst_n) begin
            check("rst_req",   32'(imem_req_o), 32'h0);
            check("rst_valid", 32'(instr_valid_o), 32'h0);
            check("rst_instr", instr_o, 32'h0);
            check("rst_pc",    pc_o, 32'h0);
        end else begin
            exp_req = (since_rst >= 1) && !redirect_i && (m_out + expq.size() < DEPTH);
            check("req", 32'(imem_req_o), 32'(exp_req));
            if (imem_req_o) check("addr", imem_addr_o, m_fetch_pc);
            exp_valid = (expq.size() != 0) && !redirect_i;
            check("valid", 32'(instr_valid_o), 32'(exp_valid));
            if (expq.size() != 0) begin
                check("pc", pc_o, expq[0].pc);
                check("instr", instr_o, expq[0].instr);
            end else begin
                check("pc_empty", pc_o, 32'h0);
                check("instr_empty", instr_o, 32'h0);
            end
            if (g) grants++;
            if (redirect_i) begin
                m_out      = m_out + int'(g) - int'(r);
                m_discard  = m_out;
                expq.delete();
                pendq.delete();
                m_fetch_pc = {redirect_pc_i[31:2], 2'b00};
            end else begin
                do_push = 1'b0;
                if (r) begin
                    m_out--;
                    if (m_discard > 0) m_discard--;
                    else begin
                        check("fifo_not_full", 32'(expq.size() < DEPTH), 32'h1);
                        pa = (pendq.size() != 0) ? pendq.pop_front() : 32'hDEAD_DEAD;
                        ne = '{pc: pa, instr: mem_word(pa)};
                        do_push = 1'b1;
                    end
                end
                if (exp_valid && instr_ready_i) begin
                    delivered.push_back(expq[0].pc);
                    void'(expq.pop_front());
                end
                if (do_push) expq.push_back(ne);
                if (g) begin
                    pendq.push_back(m_fetch_pc);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                    m_out++;
                end
            end
            since_rst++;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        int n;
        rst_n = 1'b0;
        repeat (2) cycle();
        n = 0;
        while (mq.size() != 0 && n < 20) begin cycle(); n++; end
        check("reset_drain_bound", 32'(mq.size()), 32'h0);
        mq.delete();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_two_inflight(input string tag);
        int n = 0;
        while (!(m_out == 2 && mq.size() > 0 && mq[0].due > cyc) && n < 40) begin cycle(); n++; end
        check(tag, 32'(m_out), 32'd2);
    endtask

    task automatic check_seq(input string tag, input logic [31:0] first, input int n);
        logic [31:0] e = first;
        for (int i = 0; i < n; i++) begin
            check(tag, (i < delivered.size()) ? delivered[i] : 32'hBAD0_BAD0, e);
            e = e + 32'd4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b1;
        model_reset();
        repeat (3) cycle();

        // Zero-wait memory: BOOT cycle, first request, then one instruction per cycle.
        rst_n = 1'b1;
        model_reset();
        delivered.delete();
        cycle();
        check("boot_no_req", 32'(s_req), 32'h0);
        cycle();
        check("first_req", 32'(s_req), 32'h1);
        check("first_addr", s_addr, RESET_PC);
        repeat (22) cycle();
        check("throughput", 32'(delivered.size()), 32'd21);
        check_seq("stream", RESET_PC, 21);

        // Back-pressure: credit stops fetch at DEPTH, then drains in order.
        apply_reset();
        instr_ready_i = 1'b0;
        grants = 0;
        repeat (12) cycle();
        check("fill_grants", 32'(grants), 32'(DEPTH));
        check("fill_req_low", 32'(s_req), 32'h0);
        instr_ready_i = 1'b1;
        delivered.delete();
        repeat (8) cycle();
        check_seq("drain_order", 32'h0, 5);

        // Slow memory, two in flight, redirect to an unaligned target.
        lat_min = 3; lat_max = 3; max_if = 2;
        wait_two_inflight("two_inflight");
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        delivered.delete();
        cycle();
        check("redir_valid_low", 32'(s_valid), 32'h0);
        redirect_i = 1'b0;
        repeat (16) cycle();
        check_seq("after_drain", 32'h0000_0100, 2);

        // Redirect coinciding with rvalid, ready and a non-empty FIFO.
        lat_min = 1; lat_max = 1; max_if = 16;
        repeat (8) cycle();
        check("pre_redir_valid", 32'(s_valid), 32'h1);
        redirect_i = 1'b1; redirect_pc_i = 32'h2000_0040;
        delivered.delete();
        cycle();
        check("same_cyc_valid_low", 32'(s_valid), 32'h0);
        redirect_i = 1'b0;
        cycle();
        check("flushed_valid", 32'(s_valid), 32'h0);
        check("flushed_pc", s_pc, 32'h0);
        repeat (6) cycle();
        check_seq("same_cyc_target", 32'h2000_0040, 3);

        // Address wrap past the top of memory.
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        delivered.delete();
        cycle();
        redirect_i = 1'b0;
        repeat (8) cycle();
        check_seq("wrap", 32'hFFFF_FFF8, 3);

        // Reset while two requests are in flight; late responses must vanish.
        lat_min = 3; lat_max = 3; max_if = 2;
        wait_two_inflight("rst_two_inflight");
        apply_reset();
        lat_min = 1; lat_max = 1; max_if = 16;
        delivered.delete();
        cycle();
        check("reboot_no_req", 32'(s_req), 32'h0);
        cycle();
        check("reboot_req", 32'(s_req), 32'h1);
        check("reboot_addr", s_addr, RESET_PC);
        repeat (6) cycle();
        check_seq("reboot_stream", RESET_PC, 3);

        // Randomized traffic: stalls, variable latency, random redirects.
        rand_gnt = 1'b1; lat_min = 1; lat_max = 4;
        delivered.delete();
        for (int i = 0; i < 1500; i++) begin
            instr_ready_i = ($urandom_range(3, 0) != 0);
            redirect_i    = ($urandom_range(29, 0) == 0);
            redirect_pc_i = $urandom;
            cycle();
        end
        redirect_i = 1'b0;
        check("rand_progress", 32'(delivered.size() > 100), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
